// File: rtl/dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_stall_ctrl
//
// Data-memory access controller for the MEM stage. When EX/MEM holds a load
// or store, the block issues a registered request to a variable-latency
// memory, freezes the pipeline while the access is outstanding, and captures
// the load data for MEM/WB. An access that receives no ack within TIMEOUT
// WAIT cycles is aborted and flagged through the sticky err_o.
//
// Parameters
//   TIMEOUT      WAIT cycles without an ack before the access is aborted (>=1)
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rst_i        synchronous active-high reset
//   MemRead_i    EX/MEM holds a load
//   MemWrite_i   EX/MEM holds a store
//   addr_i       data address (EX/MEM ALU result)
//   wdata_i      store data from EX/MEM
//   mem_ack_i    memory completed the access (one-cycle pulse)
//   mem_rdata_i  read data, valid with mem_ack_i
//   mem_req_o    registered request to memory
//   mem_we_o     registered write enable, valid with mem_req_o
//   mem_addr_o   latched address
//   mem_wdata_o  latched store data
//   Memdata_o    captured load data for MEM/WB
//   stall_o      freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB when 1
//   err_o        sticky timeout / illegal-access flag
// -----------------------------------------------------------------------------
module dmem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] Memdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            req_q,   req_d;
  logic            we_q,    we_d;
  logic [31:0]     addr_q,  addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     mdata_q, mdata_d;
  logic            err_q,   err_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            acc;
  logic            timeout_hit;

  assign acc         = MemRead_i | MemWrite_i;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Stall covers the detect cycle in IDLE and every WAIT cycle; DONE lets the
  // pipeline advance so MEM/WB picks up Memdata_o.
  assign stall_o = ((state_q == IDLE) & acc) | (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = WAIT;
          req_d   = 1'b1;
          // A simultaneous read+write request is issued as a write and flagged.
          we_d    = MemWrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
          if (MemRead_i & MemWrite_i) begin
            err_d = 1'b1;
          end
        end
      end

      WAIT: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            mdata_d = mem_rdata_i;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          mdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // EX/MEM still holds the completed instruction here, so acc and any
      // stray ack are ignored.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign Memdata_o   = mdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_stall_ctrl
//
// Directed scoreboard bench for dmem_stall_ctrl (TIMEOUT overridden to 4).
// Each stimulus cycle drives the inputs #1 after posedge and queues the
// hand-computed outputs expected for that cycle; a monitor samples on the
// following negedge and compares. Bus outputs (we/addr/wdata) are compared
// only in cycles where a request is expected to be active.
// -----------------------------------------------------------------------------
module tb_dmem_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] Memdata_o;
  logic        stall_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  dmem_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .Memdata_o   (Memdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic        st;
    logic        rq;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] md;
    logic        er;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    checks   = 0;
  int    failures = 0;
  exp_t  mon_e;
  string mon_n;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs, queue the outputs expected this cycle.
  task automatic cyc(input string nm, input logic r, input logic mr,
                     input logic mw, input logic [31:0] a, input logic [31:0] wd,
                     input logic ack, input logic [31:0] rd,
                     input logic e_st, input logic e_rq, input logic e_we,
                     input logic [31:0] e_a, input logic [31:0] e_wd,
                     input logic [31:0] e_md, input logic e_er);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i       = r;
    MemRead_i   = mr;
    MemWrite_i  = mw;
    addr_i      = a;
    wdata_i     = wd;
    mem_ack_i   = ack;
    mem_rdata_i = rd;
    e.st = e_st; e.rq = e_rq; e.we = e_we; e.a = e_a;
    e.wd = e_wd; e.md = e_md; e.er = e_er;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [31:0] e_md, input logic e_er);
    cyc(nm, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, e_md, e_er);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (eq.size() > 0) begin
        mon_e = eq.pop_front();
        mon_n = nq.pop_front();
        chk(mon_n, "stall", {31'b0, stall_o},   {31'b0, mon_e.st});
        chk(mon_n, "req",   {31'b0, mem_req_o}, {31'b0, mon_e.rq});
        chk(mon_n, "err",   {31'b0, err_o},     {31'b0, mon_e.er});
        chk(mon_n, "mdata", Memdata_o,          mon_e.md);
        if (mon_e.rq) begin
          chk(mon_n, "we",    {31'b0, mem_we_o}, {31'b0, mon_e.we});
          chk(mon_n, "addr",  mem_addr_o,        mon_e.a);
          chk(mon_n, "wdata", mem_wdata_o,       mon_e.wd);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0;
    wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);

    idle("rst0", 32'h0, 0);
    idle("rst1", 32'h0, 0);

    // Load, ack on 3rd WAIT cycle: 4 stall cycles then DONE
    cyc("ld_idle", 0,1,0, 32'h40,0, 0,32'h0,          1,0,0, 32'h0, 0, 32'h0, 0);
    cyc("ld_w1",   0,1,0, 32'h40,0, 0,32'h0,          1,1,0, 32'h40,0, 32'h0, 0);
    cyc("ld_w2",   0,1,0, 32'h40,0, 0,32'h0,          1,1,0, 32'h40,0, 32'h0, 0);
    cyc("ld_w3",   0,1,0, 32'h40,0, 1,32'hDEADBEEF,   1,1,0, 32'h40,0, 32'h0, 0);
    cyc("ld_done", 0,1,0, 32'h40,0, 0,32'h0,          0,0,0, 32'h0, 0, 32'hDEADBEEF, 0);
    idle("ld_after", 32'hDEADBEEF, 0);

    // Store, ack on 1st WAIT; addr_i changes mid-WAIT, latched bus must hold
    cyc("st_idle", 0,0,1, 32'h100,32'h55, 0,32'h0,    1,0,0, 0,0, 32'hDEADBEEF, 0);
    cyc("st_w1",   0,0,1, 32'h999,32'h77, 1,32'h1234, 1,1,1, 32'h100,32'h55, 32'hDEADBEEF, 0);
    cyc("st_done", 0,0,1, 32'h100,32'h55, 0,32'h0,    0,0,0, 0,0, 32'hDEADBEEF, 0);
    idle("st_after", 32'hDEADBEEF, 0);

    // Ack coincident with the timeout cycle (4th WAIT)
    cyc("co_idle", 0,1,0, 32'h80,0, 0,32'h0,          1,0,0, 0,0, 32'hDEADBEEF, 0);
    cyc("co_w1",   0,1,0, 32'h80,0, 0,32'h0,          1,1,0, 32'h80,0, 32'hDEADBEEF, 0);
    cyc("co_w2",   0,1,0, 32'h80,0, 0,32'h0,          1,1,0, 32'h80,0, 32'hDEADBEEF, 0);
    cyc("co_w3",   0,1,0, 32'h80,0, 0,32'h0,          1,1,0, 32'h80,0, 32'hDEADBEEF, 0);
    cyc("co_w4",   0,1,0, 32'h80,0, 1,32'h12345678,   1,1,0, 32'h80,0, 32'hDEADBEEF, 0);
    cyc("co_done", 0,1,0, 32'h80,0, 0,32'h0,          0,0,0, 0,0, 32'h12345678, 0);
    idle("co_after", 32'h12345678, 0);

    // Back-to-back load then store; DONE ignores acc and a stray ack
    cyc("bb_ld_idle", 0,1,0, 32'h200,0, 0,32'h0,         1,0,0, 0,0, 32'h12345678, 0);
    cyc("bb_ld_w1",   0,1,0, 32'h200,0, 1,32'hCAFEF00D,  1,1,0, 32'h200,0, 32'h12345678, 0);
    cyc("bb_ld_done", 0,1,0, 32'h200,0, 1,32'hBAD0BAD0,  0,0,0, 0,0, 32'hCAFEF00D, 0);
    cyc("bb_st_idle", 0,0,1, 32'h300,32'hA5A5, 0,32'h0,  1,0,0, 0,0, 32'hCAFEF00D, 0);
    cyc("bb_st_w1",   0,0,1, 32'h300,32'hA5A5, 0,32'h0,  1,1,1, 32'h300,32'hA5A5, 32'hCAFEF00D, 0);
    cyc("bb_st_w2",   0,0,1, 32'h300,32'hA5A5, 1,32'h0,  1,1,1, 32'h300,32'hA5A5, 32'hCAFEF00D, 0);
    cyc("bb_st_done", 0,0,1, 32'h300,32'hA5A5, 0,32'h0,  0,0,0, 0,0, 32'hCAFEF00D, 0);
    idle("bb_after", 32'hCAFEF00D, 0);

    // Timeout: 4 WAIT cycles without ack, Memdata cleared, err sticky
    cyc("to_idle", 0,1,0, 32'h44,0, 0,32'h0,   1,0,0, 0,0, 32'hCAFEF00D, 0);
    cyc("to_w1",   0,1,0, 32'h44,0, 0,32'h0,   1,1,0, 32'h44,0, 32'hCAFEF00D, 0);
    cyc("to_w2",   0,1,0, 32'h44,0, 0,32'h0,   1,1,0, 32'h44,0, 32'hCAFEF00D, 0);
    cyc("to_w3",   0,1,0, 32'h44,0, 0,32'h0,   1,1,0, 32'h44,0, 32'hCAFEF00D, 0);
    cyc("to_w4",   0,1,0, 32'h44,0, 0,32'h0,   1,1,0, 32'h44,0, 32'hCAFEF00D, 0);
    cyc("to_done", 0,1,0, 32'h44,0, 0,32'h0,   0,0,0, 0,0, 32'h0, 1);
    idle("to_after", 32'h0, 1);
    cyc("to_st_idle", 0,0,1, 32'h48,32'h7, 0,32'h0,  1,0,0, 0,0, 32'h0, 1);
    cyc("to_st_w1",   0,0,1, 32'h48,32'h7, 1,32'h0,  1,1,1, 32'h48,32'h7, 32'h0, 1);
    cyc("to_st_done", 0,0,1, 32'h48,32'h7, 0,32'h0,  0,0,0, 0,0, 32'h0, 1);

    // Reset mid-WAIT with a coincident ack, then a late ack in IDLE
    cyc("rw_idle", 0,1,0, 32'h70,0, 0,32'h0,          1,0,0, 0,0, 32'h0, 1);
    cyc("rw_w1",   0,1,0, 32'h70,0, 0,32'h0,          1,1,0, 32'h70,0, 32'h0, 1);
    cyc("rw_rst",  1,1,0, 32'h70,0, 1,32'hFFFFFFFF,   1,1,0, 32'h70,0, 32'h0, 1);
    cyc("rw_post", 0,0,0, 32'h0,0,  1,32'hFFFFFFFF,   0,0,0, 0,0, 32'h0, 0);
    idle("rw_after", 32'h0, 0);

    // Read and write together: issued as a write, err set, no capture
    cyc("rwb_idle", 0,1,1, 32'h60,32'h99, 0,32'h0,        1,0,0, 0,0, 32'h0, 0);
    cyc("rwb_w1",   0,1,1, 32'h60,32'h99, 1,32'h77777777, 1,1,1, 32'h60,32'h99, 32'h0, 1);
    cyc("rwb_done", 0,1,1, 32'h60,32'h99, 0,32'h0,        0,0,0, 0,0, 32'h0, 1);
    idle("rwb_after", 32'h0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (eq.size() == 0) break;
      @(negedge clk_i);
    end
    #1;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the number of WAIT cycles without an ack before the access is aborted.

Interface
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port MemRead_i, input, 1 bit: the EX/MEM register holds a load.
REQ-005 The block SHALL have port MemWrite_i, input, 1 bit: the EX/MEM register holds a store.
REQ-006 The block SHALL have port addr_i, input, 32 bits: the data address from EX/MEM ALU result.
REQ-007 The block SHALL have port wdata_i, input, 32 bits: the store data from EX/MEM.
REQ-008 The block SHALL have port mem_ack_i, input, 1 bit: the memory has completed the access; one-cycle pulse.
REQ-009 The block SHALL have port mem_rdata_i, input, 32 bits: the read data, valid when mem_ack_i=1.
REQ-010 The block SHALL have port mem_req_o, output, 1 bit: registered request to memory.
REQ-011 The block SHALL have port mem_we_o, output, 1 bit: registered write enable, valid with mem_req_o.
REQ-012 The block SHALL have port mem_addr_o, output, 32 bits: latched address.
REQ-013 The block SHALL have port mem_wdata_o, output, 32 bits: latched store data.
REQ-014 The block SHALL have port Memdata_o, output, 32 bits: captured load data, fed to the MEM/WB Memdata_i.
REQ-015 The block SHALL have port stall_o, output, 1 bit: freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB when 1.
REQ-016 The block SHALL have port err_o, output, 1 bit: sticky timeout/illegal-access flag.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and DONE, held in a registered state variable.
REQ-018 The access condition SHALL be acc = MemRead_i | MemWrite_i.
REQ-019 stall_o SHALL be combinational, equal to (state==IDLE & acc) | (state==WAIT), and 0 in DONE.
REQ-020 On IDLE with acc=1, the next state SHALL be WAIT.
REQ-021 On IDLE with acc=1, the block SHALL register mem_req_o=1, mem_we_o=MemWrite_i, mem_addr_o=addr_i and mem_wdata_o=wdata_i.
REQ-022 On IDLE with acc=1, the block SHALL clear the timeout counter.
REQ-023 When MemRead_i and MemWrite_i are both 1 in IDLE, the access SHALL be treated as a write and err_o SHALL be set.
REQ-024 In WAIT, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL hold stable until the state leaves WAIT.
REQ-025 In WAIT with mem_ack_i=1, the next state SHALL be DONE, mem_req_o SHALL be registered to 0, and Memdata_o SHALL capture mem_rdata_i on a read.
REQ-026 On a write, Memdata_o SHALL hold its previous value.
REQ-027 Minimum access latency SHALL be 2 stall cycles: IDLE detect plus one WAIT cycle with ack present.
REQ-028 In WAIT without ack, the counter SHALL increment, saturating at TIMEOUT.
REQ-029 When the counter reaches TIMEOUT-1 with no ack, the next state SHALL be DONE, mem_req_o SHALL be registered to 0, Memdata_o SHALL be registered to 0, and err_o SHALL be set.
REQ-030 An ack arriving in the same cycle as the timeout SHALL take priority: normal completion, err_o not set.
REQ-031 DONE SHALL last exactly one cycle, with stall_o=0 so the pipeline advances and MEM/WB captures Memdata_o.
REQ-032 In DONE, acc SHALL be ignored, because EX/MEM still holds the completed instruction.
REQ-033 The next state after DONE SHALL be IDLE.
REQ-034 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-035 err_o SHALL be sticky and cleared only by reset.
REQ-036 Back-to-back memory instructions SHALL each pay full latency, separated by exactly one DONE cycle.

Reset
REQ-037 When rst_i=1 at a posedge, the next state SHALL be IDLE, regardless of the current state.
REQ-038 When rst_i=1 at a posedge, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, Memdata_o, err_o and the counter SHALL all be 0.
REQ-039 Reset SHALL take priority over ack, timeout and acc.
REQ-040 A reset mid-WAIT SHALL abandon the access, with mem_req_o=0 on the next cycle.
REQ-041 stall_o SHALL follow from the reset state: it is 0 after reset unless acc=1.

Verification
REQ-042 Load, ack on the 3rd WAIT cycle with rdata=0xDEADBEEF: the bench SHALL see stall_o=1 for 4 cycles, then DONE with stall_o=0, Memdata_o=0xDEADBEEF and mem_req_o deasserted.
REQ-043 Store to addr 0x100 with data 0x55, ack on the 1st WAIT cycle: the bench SHALL see mem_we_o=1, mem_addr_o=0x100 and mem_wdata_o=0x55 held through WAIT, 2 stall cycles, and Memdata_o unchanged.
REQ-044 Load with TIMEOUT=4 and no ack: the bench SHALL see DONE after 4 WAIT cycles, Memdata_o=0, err_o=1, and err_o remaining 1 through later accesses.
REQ-045 Ack coincident with the timeout cycle: the bench SHALL see normal capture and err_o=0.
REQ-046 Back-to-back load then store: the bench SHALL see IDLE->WAIT->DONE->IDLE->WAIT, with DONE ignoring acc, and the second request addr taken from the new EX/MEM value.
REQ-047 rst_i=1 asserted during WAIT: the bench SHALL see state IDLE, mem_req_o=0 and err_o=0 on the next cycle, with a late mem_ack_i ignored.
